// File: rtl/cache_perf_monitor.sv
// ==========================================================================
// cache_perf_monitor: per-channel cache access/hit/miss counters, rev 1.0
// ==========================================================================
`default_nettype none

module cache_perf_monitor #(
  parameter  int NUM_CH = 2,
  parameter  int CNT_W  = 32,
  parameter  int WINDOW = 0,
  parameter  int WIN_W  = 16,
  localparam int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              clr_i,
  input  logic [NUM_CH-1:0] acc_i,
  input  logic [NUM_CH-1:0] hit_i,
  input  logic [SEL_W-1:0]  sel_i,
  output logic [CNT_W-1:0]  No_acc_o,
  output logic [CNT_W-1:0]  No_hit_o,
  output logic [CNT_W-1:0]  No_miss_o,
  output logic [NUM_CH-1:0] ovf_o,
  output logic              snap_valid_o,
  output logic              running_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  state_e state_q;
  logic   count_en;
  logic   win_end;

  logic [CNT_W-1:0] rd_acc  [NUM_CH];
  logic [CNT_W-1:0] rd_hit  [NUM_CH];
  logic [CNT_W-1:0] rd_miss [NUM_CH];

  // clr_i dominates stop_i, which dominates start_i
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else if (clr_i) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (start_i) state_q <= ST_RUN;
        ST_RUN:  if (stop_i)  state_q <= ST_HOLD;
        ST_HOLD: if (start_i) state_q <= ST_RUN;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign count_en  = (state_q == ST_RUN);
  assign running_o = count_en;

  generate
    if (WINDOW > 0) begin : g_win
      localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
      logic [WIN_W-1:0] win_q;
      logic             snap_valid_q;

      assign win_end = count_en && (win_q == WIN_LAST);

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          win_q        <= '0;
          snap_valid_q <= 1'b0;
        end else if (clr_i) begin
          win_q        <= '0;
          snap_valid_q <= 1'b0;
        end else begin
          snap_valid_q <= win_end;
          if (win_end) begin
            win_q <= '0;
          end else if (count_en) begin
            win_q <= win_q + WIN_W'(1);
          end
        end
      end

      assign snap_valid_o = snap_valid_q;
    end else begin : g_nowin
      assign win_end      = 1'b0;
      assign snap_valid_o = 1'b0;
    end
  endgenerate

  generate
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [CNT_W-1:0] acc_q, acc_d;
      logic [CNT_W-1:0] hit_q, hit_d;
      logic [CNT_W-1:0] miss_q, miss_d;
      logic             ovf_q, ovf_d;

      // a saturated counter holds and flags the lost increment instead
      always_comb begin
        acc_d  = acc_q;
        hit_d  = hit_q;
        miss_d = miss_q;
        ovf_d  = ovf_q;
        if (count_en && acc_i[c]) begin
          if (&acc_q) ovf_d = 1'b1;
          else        acc_d = acc_q + CNT_W'(1);
          if (hit_i[c]) begin
            if (&hit_q) ovf_d = 1'b1;
            else        hit_d = hit_q + CNT_W'(1);
          end else begin
            if (&miss_q) ovf_d  = 1'b1;
            else         miss_d = miss_q + CNT_W'(1);
          end
        end
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          acc_q  <= '0;
          hit_q  <= '0;
          miss_q <= '0;
          ovf_q  <= 1'b0;
        end else if (clr_i) begin
          acc_q  <= '0;
          hit_q  <= '0;
          miss_q <= '0;
          ovf_q  <= 1'b0;
        end else if (win_end) begin
          acc_q  <= '0;
          hit_q  <= '0;
          miss_q <= '0;
          ovf_q  <= ovf_d;
        end else begin
          acc_q  <= acc_d;
          hit_q  <= hit_d;
          miss_q <= miss_d;
          ovf_q  <= ovf_d;
        end
      end

      assign ovf_o[c] = ovf_q;

      if (WINDOW > 0) begin : g_snap
        logic [CNT_W-1:0] snap_acc_q, snap_hit_q, snap_miss_q;

        // the snapshot includes the events of the window's final cycle
        always_ff @(posedge clk_i or negedge rst_ni) begin
          if (!rst_ni) begin
            snap_acc_q  <= '0;
            snap_hit_q  <= '0;
            snap_miss_q <= '0;
          end else if (clr_i) begin
            snap_acc_q  <= '0;
            snap_hit_q  <= '0;
            snap_miss_q <= '0;
          end else if (win_end) begin
            snap_acc_q  <= acc_d;
            snap_hit_q  <= hit_d;
            snap_miss_q <= miss_d;
          end
        end

        assign rd_acc[c]  = snap_acc_q;
        assign rd_hit[c]  = snap_hit_q;
        assign rd_miss[c] = snap_miss_q;
      end else begin : g_live
        assign rd_acc[c]  = acc_q;
        assign rd_hit[c]  = hit_q;
        assign rd_miss[c] = miss_q;
      end
    end
  endgenerate

  // an unmatched select leaves the outputs at zero
  always_comb begin
    No_acc_o  = '0;
    No_hit_o  = '0;
    No_miss_o = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (sel_i == SEL_W'(c)) begin
        No_acc_o  = rd_acc[c];
        No_hit_o  = rd_hit[c];
        No_miss_o = rd_miss[c];
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/cache_perf_monitor.md
Name: cache_perf_monitor

Overview:
- Synthesizable, parametrised performance monitor for the RV32I cache subsystem; replaces the fixed, commented-out No_acc_o/No_hit_o/No_miss_o counters.
- Counts accesses, hits and misses on NUM_CH independent cache channels (e.g. ch0 = I-cache, ch1 = D-cache).
- Supports start/stop/clear control, saturating counters with sticky overflow flags, and an optional windowed mode that snapshots the counts every WINDOW cycles.
- Sits beside riscv_cache; its outputs are read by the top-level bench or routed to the LCD/HEX I/O.

Parameters:
- NUM_CH, 2: number of monitored cache channels (1..8).
- CNT_W, 32: width of each counter (8..32).
- WINDOW, 0: window length in cycles. 0 = free-running mode; >0 = windowed snapshot mode.
- WIN_W, 16: width of the window-cycle counter. WINDOW must be < 2^WIN_W.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset, asynchronous assert, active-low.
- start_i  in  1  begin or resume counting.
- stop_i  in  1  freeze counting; values are held.
- clr_i  in  1  synchronous clear of all counters, snapshots and flags; returns to IDLE.
- acc_i  in  NUM_CH  per-channel access strobe, one access per cycle per channel.
- hit_i  in  NUM_CH  per-channel hit qualifier; valid only when the matching acc_i bit is 1.
- sel_i  in  $clog2(NUM_CH) (min 1)  channel select for the read-out ports.
- No_acc_o  out  CNT_W  access count of the selected channel.
- No_hit_o  out  CNT_W  hit count of the selected channel.
- No_miss_o  out  CNT_W  miss count of the selected channel.
- ovf_o  out  NUM_CH  sticky per-channel saturation flag.
- snap_valid_o  out  1  one-cycle pulse when a window snapshot is captured.
- running_o  out  1  high while in the RUN state.

Behaviour:
- Reset (rst_ni = 0): all counters, snapshots, ovf_o and the window counter go to 0. State = IDLE. snap_valid_o = 0, running_o = 0.
- FSM states: IDLE, RUN, HOLD.
  - IDLE -start_i-> RUN
  - RUN -stop_i-> HOLD
  - HOLD -start_i-> RUN
  - any state -clr_i-> IDLE
- Priority when inputs coincide: clr_i > stop_i > start_i.
  - clr_i together with start_i: the next state is IDLE and everything is cleared.
  - start_i together with stop_i in RUN: go to HOLD.
- Counting happens only in RUN. The event present in the cycle that performs the transition into RUN is not counted; the event in the cycle that performs the transition to HOLD is counted.
- Per channel c, on each RUN cycle:
  - acc_i[c] = 1: acc += 1.
  - acc_i[c] = 1 and hit_i[c] = 1: hit += 1.
  - acc_i[c] = 1 and hit_i[c] = 0: miss += 1.
  - hit_i[c] with acc_i[c] = 0 is ignored.
- Updated values are visible on the outputs one cycle after the event (registered counters).
- Saturation: a counter at 2^CNT_W-1 holds its value. Any attempted increment beyond that sets ovf_o[c] = 1, which stays set until clr_i or reset. Invariant: acc = hit + miss whenever ovf_o[c] = 0.
- Free-running mode (WINDOW = 0):
  - Outputs show the live counters of channel sel_i.
  - snap_valid_o is always 0.
- Windowed mode (WINDOW > 0):
  - The window counter increments on each RUN cycle and holds in HOLD.
  - On the RUN cycle where the window counter equals WINDOW-1:
    - The snapshot registers capture the live counters, including that cycle's events.
    - The live counters are reset to 0 and the window counter wraps to 0.
    - snap_valid_o pulses high the following cycle.
  - Outputs show the snapshot registers of channel sel_i. Before the first snapshot they read 0.
  - ovf_o is not cleared at window boundaries.
- sel_i is combinational to the outputs. An out-of-range sel_i (≥ NUM_CH) drives 0 on all outputs.
- clr_i in HOLD or mid-window: everything is zeroed next cycle. The partial window is discarded and no snap_valid_o pulse is generated.
- Async reset mid-window: same effect as reset; no snapshot.

Test Plan:
1. Free-running, NUM_CH=2. Pulse start_i. Drive ch0 for 10 cycles with acc=1 and the pattern hit=1,1,0 repeated; idle ch1. Then stop_i. -> sel=0 reads acc=10, hit=7, miss=3; sel=1 reads 0/0/0; running_o=0.
2. HOLD/resume. Stop after 4 accesses, drive 5 accesses while in HOLD, then start_i and drive 3 more. -> acc=7; accesses made during HOLD are not counted.
3. Saturation, CNT_W=8. Run 300 consecutive all-hit accesses on ch1. -> acc=255, hit=255, miss=0, ovf_o=2'b10; values hold on further accesses.
4. Windowed, WINDOW=8. Start, then acc=1 every cycle with all misses. -> snap_valid_o pulses every 8 cycles; each snapshot reads acc=8, hit=0, miss=8; outputs read 0 before the first pulse.
5. Simultaneous clr_i+start_i in RUN with counts present. -> state IDLE, all outputs 0, ovf_o=0, running_o=0; a later start_i counts from 0.
6. Assert rst_ni=0 mid-window for 2 cycles (async, not clock-aligned). -> outputs 0 immediately, no snap_valid_o pulse, state IDLE after release.
